// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port byte-addressed data memory.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic        r0_half,
    input  logic        r0_byte,
    input  logic        r0_uns,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic        r1_half,
    input  logic        r1_byte,
    input  logic        r1_uns,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic        r1_err,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic        m_re,
    output logic        m_half,
    output logic        m_byte,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    function automatic logic [31:0] f_extend(input logic [31:0] d, input logic half,
                                             input logic byt, input logic uns);
        logic [31:0] res;
        if (half) begin
            res = {{16{~uns & d[15]}}, d[15:0]};
        end else if (byt) begin
            res = {{24{~uns & d[7]}}, d[7:0]};
        end else begin
            res = d;
        end
        return res;
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    function automatic logic f_misaligned(input logic [1:0] a, input logic half,
                                          input logic byt);
        logic bad;
        if (half) begin
            bad = a[0];
        end else if (byt) begin
            bad = 1'b0;
        end else begin
            bad = |a;
        end
        return bad;
    endfunction
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic        r_owner;
    logic        r_we;
    logic        r_uns;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic        r_m_half;
    logic        r_m_byte;
    logic        r_m_we;
    logic        r_m_re;
    logic        r_err0;
    logic        r_err1;

    logic        w_idle;
    logic        w_sel1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any_gnt;
    logic        w_trap;
    logic        w_fwd;
    logic        w_sel_we;
    logic        w_sel_half;
    logic        w_sel_byte;
    logic        w_sel_uns;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_ext;
    logic        w_resp;

    // Port 1 wins when port 0 is quiet or has used up its consecutive-grant budget.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_sel1    = r1_req & (~r0_req | (r_starve_cnt == LP_LIMIT));
    assign w_gnt0    = w_idle & r0_req & ~w_sel1;
    assign w_gnt1    = w_idle & w_sel1;
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign w_sel_we    = w_sel1 ? r1_we    : r0_we;
    assign w_sel_half  = w_sel1 ? r1_half  : r0_half;
    assign w_sel_byte  = w_sel1 ? r1_byte  : r0_byte;
    assign w_sel_uns   = w_sel1 ? r1_uns   : r0_uns;
    assign w_sel_addr  = w_sel1 ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_sel1 ? r1_wdata : r0_wdata;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_trap = w_any_gnt & f_misaligned(w_sel_addr[1:0], w_sel_half, w_sel_byte);
`else
    assign w_trap = 1'b0;
`endif
    assign w_fwd = w_any_gnt & ~w_trap;

    // Next-state logic for the transaction sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fwd) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_we) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winner's attributes; address, data and size then hold until the next access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_uns     <= 1'b0;
            r_m_addr  <= 32'h0000_0000;
            r_m_wdata <= 32'h0000_0000;
            r_m_half  <= 1'b0;
            r_m_byte  <= 1'b0;
        end else if (w_fwd) begin
            r_owner   <= w_gnt1;
            r_we      <= w_sel_we;
            r_uns     <= w_sel_uns;
            r_m_addr  <= w_sel_addr;
            r_m_wdata <= w_sel_wdata;
            r_m_half  <= w_sel_half;
            r_m_byte  <= w_sel_byte & ~w_sel_half;
        end else begin
            r_owner   <= r_owner;
            r_we      <= r_we;
            r_uns     <= r_uns;
            r_m_addr  <= r_m_addr;
            r_m_wdata <= r_m_wdata;
            r_m_half  <= r_m_half;
            r_m_byte  <= r_m_byte;
        end
    end

    // Memory strobes are high only in the ACCESS cycle following a forwarded grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_we <= 1'b0;
            r_m_re <= 1'b0;
        end else begin
            r_m_we <= w_fwd & w_sel_we;
            r_m_re <= w_fwd & ~w_sel_we;
        end
    end

    // Misalignment error pulses, one cycle after the trapped grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            r_err0 <= w_gnt0 & w_trap;
            r_err1 <= w_gnt1 & w_trap;
        end
    end

    // Bounded-wait counter: counts port-0 wins while port 1 is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_gnt1 || !r1_req) begin
            r_starve_cnt <= 4'd0;
        end else if (w_gnt0 && (r_starve_cnt != LP_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Read data is zeroed outside the response cycle so idle ports see 0.
    assign w_resp = (r_state == ST_RESP);
    assign w_ext  = f_extend(m_rdata, r_m_half, r_m_byte, r_uns);

    assign r0_gnt    = w_gnt0;
    assign r1_gnt    = w_gnt1;
    assign r0_rvalid = w_resp & ~r_owner;
    assign r1_rvalid = w_resp & r_owner;
    assign r0_rdata  = (w_resp & ~r_owner) ? w_ext : 32'h0000_0000;
    assign r1_rdata  = (w_resp & r_owner)  ? w_ext : 32'h0000_0000;
    assign r0_err    = r_err0;
    assign r1_err    = r_err1;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign m_half    = r_m_half;
    assign m_byte    = r_m_byte;
    assign m_we      = r_m_we;
    assign m_re      = r_m_re;

endmodule
